// File: rtl/div_nr_seq_pkg.sv
// Shared types/constants for the non-restoring divider.
// Optional signed mode is controlled by DIV_SIGNED_EN (see div_nr_seq.sv).
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = DIV_WIDTH;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ITER, S_CORRECT, S_SFIX, S_DONE
  } div_state_e;
endpackage

// File: rtl/div_nr_seq_if.sv
// Start/result handshake shared by the divide (and multiply) sequencers.
// op_signed exists only when DIV_SIGNED_EN is defined.
interface div_nr_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef DIV_SIGNED_EN
  logic             op_signed;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

`ifdef DIV_SIGNED_EN
  modport master (output start, dividend, divisor, op_signed,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor, op_signed,
                  output busy, done, quotient, remainder, div_by_zero);
`else
  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
`endif
endinterface

// File: rtl/div_nr_seq_addsub33.sv
// Combinational W-bit add/subtract: sum = a + (b ^ {W{sub}}) + sub.
module div_addsub33 #(parameter int W = 33) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);
  logic [W-1:0] w_b;

  assign w_b = b ^ {W{sub}};
  assign sum = a + w_b + {{(W-1){1'b0}}, sub};
endmodule

// File: rtl/div_nr_seq.sv
// Sequential non-restoring divider: one quotient bit per cycle, then remainder fix-up.
// DIV_SIGNED_EN adds op_signed and a sign-fix (SFIX) state.
module div_nr_seq import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  div_nr_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  div_state_e       r_state, w_next;
  logic [WIDTH:0]   r_a, r_m;
  logic [WIDTH-1:0] r_q, r_quot, r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_dbz;
`ifdef DIV_SIGNED_EN
  logic             r_neg_q, r_neg_r;
`endif

  logic             w_accept, w_dz, w_sub;
  logic [WIDTH-1:0] w_dvd, w_dvs;
  logic [WIDTH:0]   w_a_shl, w_add_a, w_sum, w_a_fix;

  assign w_accept = (r_state == S_IDLE || r_state == S_DONE) && bus.start;
  assign w_dz     = (bus.divisor == '0);

`ifdef DIV_SIGNED_EN
  assign w_dvd = (bus.op_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign w_dvs = (bus.op_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
`else
  assign w_dvd = bus.dividend;
  assign w_dvs = bus.divisor;
`endif

  // ITER: shifted A +/- M (subtract while A is non-negative); CORRECT: A + M
  assign w_a_shl = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_sub   = (r_state == S_ITER) ? ~r_a[WIDTH] : 1'b0;
  assign w_add_a = (r_state == S_ITER) ? w_a_shl : r_a;
  assign w_a_fix = r_a[WIDTH] ? w_sum : r_a;

  div_addsub33 #(.W(WIDTH+1)) u_addsub (
    .a(w_add_a), .b(r_m), .sub(w_sub), .sum(w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_accept ? (w_dz ? S_DONE : S_ITER) : S_IDLE;
      S_ITER:         if (r_cnt == CW'(WIDTH-1)) w_next = S_CORRECT;
`ifdef DIV_SIGNED_EN
      S_CORRECT:      w_next = S_SFIX;
`else
      S_CORRECT:      w_next = S_DONE;
`endif
      S_SFIX:         w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (r_state == S_ITER) || (r_state == S_CORRECT) || (r_state == S_SFIX);
    bus.done        = (r_state == S_DONE);
    bus.quotient    = r_quot;
    bus.remainder   = r_rem;
    bus.div_by_zero = r_dbz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_m    <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else if (w_accept) begin
      if (w_dz) begin
        // divide-by-zero reports the raw dividend, even in signed mode
        r_quot <= '1;
        r_rem  <= bus.dividend;
        r_dbz  <= 1'b1;
      end else begin
        r_a   <= '0;
        r_q   <= w_dvd;
        r_m   <= {1'b0, w_dvs};
        r_cnt <= '0;
`ifdef DIV_SIGNED_EN
        r_neg_q <= bus.op_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
        r_neg_r <= bus.op_signed && bus.dividend[WIDTH-1];
`endif
      end
    end else begin
      case (r_state)
        S_ITER: begin
          r_a   <= w_sum;
          r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
          r_cnt <= r_cnt + 1'b1;
        end
        S_CORRECT: begin
          r_a <= w_a_fix;
`ifndef DIV_SIGNED_EN
          r_quot <= r_q;
          r_rem  <= w_a_fix[WIDTH-1:0];
          r_dbz  <= 1'b0;
`endif
        end
`ifdef DIV_SIGNED_EN
        S_SFIX: begin
          r_quot <= r_neg_q ? -r_q : r_q;
          r_rem  <= r_neg_r ? -r_a[WIDTH-1:0] : r_a[WIDTH-1:0];
          r_dbz  <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_nr_seq.sv
// Directed bench for div_nr_seq: arithmetic model + per-cycle compare, plus literal checks.
module tb_div_nr_seq;
`ifdef DIV_SIGNED_EN
  localparam int LAT = 35;
`else
  localparam int LAT = 34;
`endif

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t eq[$];

  div_nr_seq_if #(.WIDTH(32)) bus();
  div_nr_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    exp_t e;
    e.dz = 1'b0;
    e.cyc = 0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000; e.r = 32'd0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
    end else begin
      e.q = a / b; e.r = a % b;
    end
    e.lat = e.dz ? 1 : LAT;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // compare process: sampled 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (bus.done) begin
        if (eq.size() == 0) chk("spurious_done", 32'(bus.done), 32'd0);
        else begin
          exp_t e;
          e = eq.pop_front();
          chk("model_quotient", bus.quotient, e.q);
          chk("model_remainder", bus.remainder, e.r);
          chk("model_dbz", 32'(bus.div_by_zero), 32'(e.dz));
          chk("model_latency", 32'(cyc - e.cyc), 32'(e.lat));
          chk("busy_in_done", 32'(bus.busy), 32'd0);
        end
      end else if (eq.size() != 0 && cyc > eq[0].cyc) begin
        chk("busy_inflight", 32'(bus.busy), 32'd1);
      end else if (eq.size() == 0) begin
        chk("busy_idle", 32'(bus.busy), 32'd0);
      end
    end
  end

  // called at a falling edge; returns one falling edge later with start dropped
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    exp_t e;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
`ifdef DIV_SIGNED_EN
    bus.op_signed = sgn;
`endif
    e = model(a, b, sgn);
    e.cyc = cyc;
    eq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done expected done within 80 cycles");
    end
  endtask

  task automatic run(input string nm, input logic [31:0] a, input logic [31:0] b, input logic sgn,
                     input logic [31:0] xq, input logic [31:0] xr, input logic xdz);
    issue(a, b, sgn);
    wait_done();
    chk({nm, "_q"}, bus.quotient, xq);
    chk({nm, "_r"}, bus.remainder, xr);
    chk({nm, "_dz"}, 32'(bus.div_by_zero), 32'(xdz));
  endtask

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
`ifdef DIV_SIGNED_EN
    bus.op_signed = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_q", bus.quotient, 32'd0);
    chk("rst_r", bus.remainder, 32'd0);
    chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run("d100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    repeat (3) @(negedge clk);

    // second op launched in the done cycle of the first
    run("dmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run("d3_10", 32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 1'b0);
    repeat (2) @(negedge clk);

    run("d5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    repeat (2) @(negedge clk);

    issue(32'd1000, 32'd3, 1'b0);
    repeat (8) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd8; bus.divisor = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    chk("ign_q", bus.quotient, 32'd333);
    chk("ign_r", bus.remainder, 32'd1);
    repeat (2) @(negedge clk);

    issue(32'd1000, 32'd3, 1'b0);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    eq.delete();
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_q", bus.quotient, 32'd0);
    chk("midrst_r", bus.remainder, 32'd0);
    chk("midrst_dz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("d9_4", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0);

    run("d0_5", 32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0);
    run("d7_7", 32'd7, 32'd7, 1'b0, 32'd1, 32'd0, 1'b0);
    run("dmin_max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0);
    run("d12345678_1000", 32'd12345678, 32'd1000, 1'b0, 32'd12345, 32'd678, 1'b0);
    run("d1_max", 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd1, 1'b0);
    run("dbig_big", 32'hDEAD_BEEF, 32'h0001_0000, 1'b0, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0);
    run("d0_0", 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1);
    run("d1_3", 32'd1, 32'd3, 1'b0, 32'd0, 32'd1, 1'b0);
`ifdef DIV_SIGNED_EN
    run("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    run("s_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0);
    run("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run("s_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
`endif
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(eq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
